ads1115_i2c_target: RTL and testbench

I2C target (slave) that models the ADS1115 register interface as seen from the bus. It pairs with the ADS1115 controller and its I2C master in loop-back benches and FPGA self-tests. It also lets a board without the real converter answer the same transactions. It decodes START/STOP, address, pointer, and 16-bit register write/read sequences on open-drain SCL/SDA. Conversion data comes from a fabric-side input.

---
 rtl/ads1115_i2c_target_pkg.sv | 28 ++
 rtl/ads1115_i2c_target_bus_sync.sv | 42 ++++
 rtl/ads1115_i2c_target.sv | 181 ++++++++++++++++++
 tb/tb_ads1115_i2c_target.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads1115_i2c_target_pkg.sv
// Shared constants for the ADS1115 I2C target model:
// register pointers, bus addresses and FSM encoding.
package ads1115_i2c_target_pkg;

   localparam logic [1:0] PTR_CONVERSION = 2'd0;
   localparam logic [1:0] PTR_CONFIG     = 2'd1;
   localparam logic [1:0] PTR_LO_THRESH  = 2'd2;
   localparam logic [1:0] PTR_HI_THRESH  = 2'd3;

   localparam logic [6:0] ADDR_GND = 7'b1001000;
   localparam logic [6:0] ADDR_VDD = 7'b1001001;
   localparam logic [6:0] ADDR_SDA = 7'b1001010;
   localparam logic [6:0] ADDR_SCL = 7'b1001011;

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_ADDR       = 4'd1;
   localparam logic [3:0] S_ADDR_ACK   = 4'd2;
   localparam logic [3:0] S_PTR        = 4'd3;
   localparam logic [3:0] S_PTR_ACK    = 4'd4;
   localparam logic [3:0] S_WR_MSB     = 4'd5;
   localparam logic [3:0] S_WR_MSB_ACK = 4'd6;
   localparam logic [3:0] S_WR_LSB     = 4'd7;
   localparam logic [3:0] S_WR_LSB_ACK = 4'd8;
   localparam logic [3:0] S_RD_BYTE    = 4'd9;
   localparam logic [3:0] S_RD_ACK     = 4'd10;
   localparam logic [3:0] S_WAIT_STOP  = 4'd11;

endpackage

// File: rtl/ads1115_i2c_target_bus_sync.sv
// SCL/SDA synchronizers and edge detection; the bus idles high,
// so every flop resets to 1 to avoid a spurious event at reset exit.
module i2c_bus_sync (
   input  logic clk_in,
   input  logic n_rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] scl_q;
   logic [1:0] sda_q;
   logic       scl_d;
   logic       sda_d;
   logic       scl_s;

   always_ff @(posedge clk_in or negedge n_rst) begin
      if (!n_rst) begin
         scl_q <= 2'b11;
         sda_q <= 2'b11;
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_q <= {scl_q[0], scl_in};
         sda_q <= {sda_q[0], sda_in};
         scl_d <= scl_q[1];
         sda_d <= sda_q[1];
      end
   end

   assign scl_s     = scl_q[1];
   assign sda_s     = sda_q[1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/ads1115_i2c_target.sv
// ADS1115 register-map I2C target: pointer, config, thresholds
// and a fabric-loaded conversion register behind a read shadow.
module ads1115_i2c_target
   import ads1115_i2c_target_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = ADDR_GND,
   parameter logic [15:0] CONFIG_RST  = 16'h8583,
   parameter logic [15:0] LO_RST      = 16'h8000,
   parameter logic [15:0] HI_RST      = 16'h7FFF
) (
   input  logic        clk_in,
   input  logic        n_rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] conv_data_in,
   input  logic        conv_valid_in,
   output logic [15:0] config_out,
   output logic [15:0] lo_thresh_out,
   output logic [15:0] hi_thresh_out,
   output logic        reg_wr_pulse,
   output logic        busy
);

   logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
   logic [3:0]  state;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift, tx, msb_buf, next_byte;
   logic [1:0]  ptr;
   logic        rw, nack, rd_lsb;
   logic [15:0] shadow, conv_reg, sel_reg;

   i2c_bus_sync u_sync (
      .clk_in    (clk_in),
      .n_rst     (n_rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   always_comb begin
      sel_reg = conv_reg;
      unique case (ptr)
         PTR_CONVERSION: sel_reg = conv_reg;
         PTR_CONFIG:     sel_reg = config_out;
         PTR_LO_THRESH:  sel_reg = lo_thresh_out;
         PTR_HI_THRESH:  sel_reg = hi_thresh_out;
      endcase
   end

   assign next_byte = rd_lsb ? shadow[7:0] : shadow[15:8];

   always_ff @(posedge clk_in or negedge n_rst) begin
      if (!n_rst) conv_reg <= 16'h0000;
      else if (conv_valid_in) conv_reg <= conv_data_in;
   end

   always_ff @(posedge clk_in or negedge n_rst) begin
      if (!n_rst) begin
         state         <= S_IDLE;
         bit_cnt       <= 4'd0;
         shift         <= 8'h00;
         tx            <= 8'h00;
         msb_buf       <= 8'h00;
         ptr           <= PTR_CONVERSION;
         rw            <= 1'b0;
         nack          <= 1'b0;
         rd_lsb        <= 1'b0;
         shadow        <= 16'h0000;
         sda_oe        <= 1'b0;
         busy          <= 1'b0;
         reg_wr_pulse  <= 1'b0;
         config_out    <= CONFIG_RST;
         lo_thresh_out <= LO_RST;
         hi_thresh_out <= HI_RST;
      end else begin
         reg_wr_pulse <= 1'b0;
         if (start_det) begin
            state   <= S_ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
         end else if (stop_det) begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (scl_rise) begin
            if (state inside {S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB, S_RD_BYTE}) begin
               shift   <= {shift[6:0], sda_s};
               bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == S_RD_ACK) nack <= sda_s;
         end else if (scl_fall) begin
            case (state)
               S_ADDR: if (bit_cnt == 4'd8) begin
                  bit_cnt <= 4'd0;
                  if (shift[7:1] == TARGET_ADDR) begin
                     state  <= S_ADDR_ACK;
                     rw     <= shift[0];
                     sda_oe <= 1'b1;
                     busy   <= 1'b1;
                  end else begin
                     state <= S_WAIT_STOP;
                     busy  <= 1'b0;
                  end
               end
               S_ADDR_ACK: if (rw) begin
                  // Snapshot keeps MSB and LSB from one sample
                  state  <= S_RD_BYTE;
                  shadow <= sel_reg;
                  rd_lsb <= 1'b1;
                  sda_oe <= ~sel_reg[15];
                  tx     <= {sel_reg[14:8], 1'b0};
               end else begin
                  state  <= S_PTR;
                  sda_oe <= 1'b0;
               end
               S_PTR: if (bit_cnt == 4'd8) begin
                  bit_cnt <= 4'd0;
                  ptr     <= shift[1:0];
                  state   <= S_PTR_ACK;
                  sda_oe  <= 1'b1;
               end
               S_PTR_ACK: begin
                  state  <= S_WR_MSB;
                  sda_oe <= 1'b0;
               end
               S_WR_MSB: if (bit_cnt == 4'd8) begin
                  bit_cnt <= 4'd0;
                  msb_buf <= shift;
                  state   <= S_WR_MSB_ACK;
                  sda_oe  <= 1'b1;
               end
               S_WR_MSB_ACK: begin
                  state  <= S_WR_LSB;
                  sda_oe <= 1'b0;
               end
               S_WR_LSB: if (bit_cnt == 4'd8) begin
                  bit_cnt <= 4'd0;
                  state   <= S_WR_LSB_ACK;
                  sda_oe  <= 1'b1;
               end
               S_WR_LSB_ACK: begin
                  state        <= S_PTR;
                  sda_oe       <= 1'b0;
                  reg_wr_pulse <= (ptr != PTR_CONVERSION);
                  unique case (ptr)
                     PTR_CONVERSION: ;
                     PTR_CONFIG:     config_out    <= {msb_buf, shift};
                     PTR_LO_THRESH:  lo_thresh_out <= {msb_buf, shift};
                     PTR_HI_THRESH:  hi_thresh_out <= {msb_buf, shift};
                  endcase
               end
               S_RD_BYTE: if (bit_cnt == 4'd8) begin
                  bit_cnt <= 4'd0;
                  state   <= S_RD_ACK;
                  sda_oe  <= 1'b0;
               end else begin
                  sda_oe <= ~tx[7];
                  tx     <= {tx[6:0], 1'b0};
               end
               S_RD_ACK: if (nack) begin
                  state  <= S_WAIT_STOP;
                  sda_oe <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  state  <= S_RD_BYTE;
                  rd_lsb <= ~rd_lsb;
                  sda_oe <= ~next_byte[7];
                  tx     <= {next_byte[6:0], 1'b0};
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ads1115_i2c_target.sv
// Bench for ads1115_i2c_target: bit-banged I2C master, response
// scoreboard and register-write pulse monitor.
module tb_ads1115_i2c_target;

   logic        clk_in = 1'b0;
   logic        n_rst = 1'b0;
   logic        scl = 1'b1;
   logic        m_low = 1'b0;
   logic        sda_oe;
   logic [15:0] conv_data_in = 16'h0000;
   logic        conv_valid_in = 1'b0;
   logic [15:0] config_out, lo_thresh_out, hi_thresh_out;
   logic        reg_wr_pulse, busy;
   logic        sda_line;

   assign sda_line = ~(m_low | sda_oe);

   ads1115_i2c_target dut (
      .clk_in        (clk_in),
      .n_rst         (n_rst),
      .scl_in        (scl),
      .sda_in        (sda_line),
      .sda_oe        (sda_oe),
      .conv_data_in  (conv_data_in),
      .conv_valid_in (conv_valid_in),
      .config_out    (config_out),
      .lo_thresh_out (lo_thresh_out),
      .hi_thresh_out (hi_thresh_out),
      .reg_wr_pulse  (reg_wr_pulse),
      .busy          (busy)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;

   typedef struct {
      int          idx;
      logic [15:0] v;
   } wr_t;

   string       exp_name[$];
   logic [15:0] exp_val[$];
   logic [15:0] obs_val[$];
   wr_t         wr_q[$];
   event        obs_ev;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_rsp(input string nm, input logic [15:0] v);
      exp_name.push_back(nm);
      exp_val.push_back(v);
   endtask

   task automatic q();
      repeat (10) @(posedge clk_in);
      #1;
   endtask

   task automatic i2c_start();
      m_low = 1'b0;
      q();
      scl = 1'b1;
      q();
      m_low = 1'b1;
      q();
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      q();
      m_low = 1'b1;
      q();
      scl = 1'b1;
      q();
      m_low = 1'b0;
      q();
   endtask

   task automatic send_bit(input logic b);
      q();
      m_low = ~b;
      q();
      scl = 1'b1;
      q();
      q();
      scl = 1'b0;
   endtask

   // ack_lvl: 0 = target must ACK, 1 = target must leave SDA high
   task automatic wr_byte(input logic [7:0] b, input string nm,
                          input logic ack_lvl);
      logic s;
      expect_rsp(nm, {15'd0, ack_lvl});
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      q();
      m_low = 1'b0;
      q();
      scl = 1'b1;
      q();
      s = sda_line;
      q();
      scl = 1'b0;
      obs_val.push_back({15'd0, s});
      ->obs_ev;
   endtask

   task automatic rd_byte(input logic [7:0] exp, input string nm,
                          input logic m_ack);
      logic [7:0] b;
      b = 8'h00;
      expect_rsp(nm, {8'h00, exp});
      for (int i = 0; i < 8; i++) begin
         q();
         m_low = 1'b0;
         q();
         scl = 1'b1;
         q();
         b = {b[6:0], sda_line};
         q();
         scl = 1'b0;
      end
      q();
      m_low = m_ack;
      q();
      scl = 1'b1;
      q();
      q();
      scl = 1'b0;
      obs_val.push_back({8'h00, b});
      ->obs_ev;
   endtask

   task automatic load_conv(input logic [15:0] v);
      @(negedge clk_in);
      conv_data_in  = v;
      conv_valid_in = 1'b1;
      @(negedge clk_in);
      conv_valid_in = 1'b0;
   endtask

   initial begin : rsp_monitor
      forever begin
         @(obs_ev);
         while (obs_val.size() > 0) begin
            if (exp_val.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got %h expected none",
                        obs_val.pop_front());
            end else begin
               chk(exp_name.pop_front(), obs_val.pop_front(),
                   exp_val.pop_front());
            end
         end
      end
   end

   initial begin : wr_monitor
      wr_t w;
      forever begin
         @(posedge clk_in);
         #1;
         if (reg_wr_pulse === 1'b1) begin
            pulse_cnt++;
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wr_pulse: got 1 expected 0");
            end else begin
               w = wr_q.pop_front();
               case (w.idx)
                  1: chk("wr_config", config_out, w.v);
                  2: chk("wr_lo", lo_thresh_out, w.v);
                  default: chk("wr_hi", hi_thresh_out, w.v);
               endcase
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin : stim
      int p0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_pulse", {15'd0, reg_wr_pulse}, 16'd0);
      chk("rst_config", config_out, 16'h8583);
      chk("rst_lo", lo_thresh_out, 16'h8000);
      chk("rst_hi", hi_thresh_out, 16'h7FFF);
      n_rst = 1'b1;
      q();

      // config write
      wr_q.push_back('{1, 16'hC288});
      i2c_start();
      wr_byte(8'h90, "cfg_addr_ack", 1'b0);
      chk("cfg_busy", {15'd0, busy}, 16'd1);
      wr_byte(8'h01, "cfg_ptr_ack", 1'b0);
      wr_byte(8'hC2, "cfg_msb_ack", 1'b0);
      wr_byte(8'h88, "cfg_lsb_ack", 1'b0);
      i2c_stop();
      chk("cfg_value", config_out, 16'hC288);
      chk("cfg_pulses", 16'(pulse_cnt), 16'd1);
      chk("cfg_busy_after_stop", {15'd0, busy}, 16'd0);

      // conversion read with repeated START
      load_conv(16'h1234);
      i2c_start();
      wr_byte(8'h90, "rd_addrw_ack", 1'b0);
      wr_byte(8'h00, "rd_ptr_ack", 1'b0);
      i2c_start();
      wr_byte(8'h91, "rd_addrr_ack", 1'b0);
      rd_byte(8'h12, "rd_msb", 1'b1);
      rd_byte(8'h34, "rd_lsb", 1'b0);
      q();
      chk("rd_release", {15'd0, sda_oe}, 16'd0);
      chk("rd_busy_nack", {15'd0, busy}, 16'd0);
      i2c_stop();

      // wrong address
      i2c_start();
      wr_byte(8'h92, "bad_addr_nack", 1'b1);
      chk("bad_busy", {15'd0, busy}, 16'd0);
      wr_byte(8'h01, "bad_byte_nack", 1'b1);
      chk("bad_config", config_out, 16'hC288);
      i2c_stop();

      // coherency across a mid-read conversion update
      i2c_start();
      wr_byte(8'h91, "coh_addr_ack", 1'b0);
      rd_byte(8'h12, "coh_msb", 1'b1);
      load_conv(16'hABCD);
      rd_byte(8'h34, "coh_lsb", 1'b0);
      i2c_stop();
      i2c_start();
      wr_byte(8'h91, "coh2_addr_ack", 1'b0);
      rd_byte(8'hAB, "coh2_msb", 1'b1);
      rd_byte(8'hCD, "coh2_lsb", 1'b0);
      i2c_stop();

      // write to read-only conversion register
      p0 = pulse_cnt;
      i2c_start();
      wr_byte(8'h90, "p0_addr_ack", 1'b0);
      wr_byte(8'h00, "p0_ptr_ack", 1'b0);
      wr_byte(8'hFF, "p0_msb_ack", 1'b0);
      wr_byte(8'hFF, "p0_lsb_ack", 1'b0);
      i2c_stop();
      chk("p0_no_pulse", 16'(pulse_cnt - p0), 16'd0);
      i2c_start();
      wr_byte(8'h91, "p0rd_addr_ack", 1'b0);
      rd_byte(8'hAB, "p0rd_msb", 1'b1);
      rd_byte(8'hCD, "p0rd_lsb", 1'b0);
      i2c_stop();

      // lo_thresh write
      wr_q.push_back('{2, 16'h0123});
      i2c_start();
      wr_byte(8'h90, "lo_addr_ack", 1'b0);
      wr_byte(8'h02, "lo_ptr_ack", 1'b0);
      wr_byte(8'h01, "lo_msb_ack", 1'b0);
      wr_byte(8'h23, "lo_lsb_ack", 1'b0);
      i2c_stop();
      chk("lo_value", lo_thresh_out, 16'h0123);

      // reset in the middle of a hi_thresh LSB
      i2c_start();
      wr_byte(8'h90, "rst_addr_ack", 1'b0);
      wr_byte(8'h03, "rst_ptr_ack", 1'b0);
      wr_byte(8'h12, "rst_msb_ack", 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      q();
      n_rst = 1'b0;
      #1;
      chk("midrst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk("midrst_busy", {15'd0, busy}, 16'd0);
      chk("midrst_hi", hi_thresh_out, 16'h7FFF);
      chk("midrst_lo", lo_thresh_out, 16'h8000);
      m_low = 1'b0;
      scl = 1'b1;
      q();
      n_rst = 1'b1;
      q();

      // post-reset transaction proves the target returned to idle
      wr_q.push_back('{3, 16'h1357});
      i2c_start();
      wr_byte(8'h90, "post_addr_ack", 1'b0);
      wr_byte(8'h03, "post_ptr_ack", 1'b0);
      wr_byte(8'h13, "post_msb_ack", 1'b0);
      wr_byte(8'h57, "post_lsb_ack", 1'b0);
      i2c_stop();
      chk("post_hi", hi_thresh_out, 16'h1357);
      chk("post_busy", {15'd0, busy}, 16'd0);

      q();
      chk("rsp_drained", 16'(exp_val.size()), 16'd0);
      chk("wr_drained", 16'(wr_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
